// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the instruction cache: word type and fetch-address field layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Field layout of a fetch address for the default 16-frame cache.
    localparam int ICACHE_IDX_W = 4;

    typedef struct packed {
        logic [29-ICACHE_IDX_W:0] tag;
        logic [ICACHE_IDX_W-1:0]  idx;
        logic [1:0]               bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_frames.sv
// Direct-mapped frame store: valid/tag/data per set, one synchronous write port, one combinational read port.
module icache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS    = 16,
    parameter int INDEX_W = $clog2(SETS),
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               wen,
    input  logic [INDEX_W-1:0] widx,
    input  logic [TAG_W-1:0]   wtag,
    input  word_t              wdata,
    input  logic [INDEX_W-1:0] ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output word_t              rdata
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    word_t            data [SETS];

    // Only valid bits are cleared; a write in the reset cycle is dropped.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
        end else if (wen) begin
            valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && wen) begin
            tags[widx] <= wtag;
            data[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = data[ridx];

endmodule

// File: rtl/icache.sv
// Blocking direct-mapped instruction cache: serves hits combinationally, fetches one word per miss.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload,
    output word_t hit_count,
    output word_t miss_count
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 30 - INDEX_W;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

    icache_state_t      state, next_state;
    word_t              miss_addr;
    word_t              fetch_addr;
    logic               hit;
    logic               miss_start;
    logic               fill_en;
    logic               rvalid;
    logic [TAG_W-1:0]   rtag;

    assign fetch_addr = imemaddr & ~32'h3;
    assign fill_en    = (state == FETCH) && !iwait;
    assign hit        = imemREN && rvalid && (rtag == fetch_addr[31:INDEX_W+2]);

    icache_frames #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .wen    (fill_en),
        .widx   (miss_addr[INDEX_W+1:2]),
        .wtag   (miss_addr[31:INDEX_W+2]),
        .wdata  (iload),
        .ridx   (fetch_addr[INDEX_W+1:2]),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (imemload)
    );

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        case (state)
            IDLE: begin
                ihit = hit;
                if (imemREN && !hit) begin
                    miss_start = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                // The fill always completes, even if the datapath has moved on.
                if (!iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss_start) begin
                miss_addr <= fetch_addr;
            end
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
